// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - round-robin register file write-port arbiter with pending-write scoreboard
//
// Purpose:
//   Shares the single register file write port between the ALU and MEM
//   writeback requesters. It uses round-robin arbitration with valid/ready
//   handshakes. It also tracks outstanding writes in a 32-entry scoreboard
//   and stalls any issue that reads or targets a pending register.
//
// Ports:
//   clk, reset                      clock, asynchronous active-low reset
//   alu_valid_i/rd_i/data_i         ALU writeback request, alu_ready_o grant
//   mem_valid_i/rd_i/data_i         MEM writeback request, mem_ready_o grant
//   issue_valid_i, issue_rd_i       issuing instruction and its destination
//   Read_Register_1_i/2_i           source registers of the issuing instruction
//   issue_stall_o                   hazard; the issue must be held
//   Reg_Write_o, Write_Register_o,  registered register file write port
//   Write_Data_o
//   pending_o                       scoreboard, bit k = write to rk outstanding

module regfile_port_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         alu_valid_i,
    input  logic [4:0]   alu_rd_i,
    input  logic [N-1:0] alu_data_i,
    output logic         alu_ready_o,
    input  logic         mem_valid_i,
    input  logic [4:0]   mem_rd_i,
    input  logic [N-1:0] mem_data_i,
    output logic         mem_ready_o,
    input  logic         issue_valid_i,
    input  logic [4:0]   issue_rd_i,
    input  logic [4:0]   Read_Register_1_i,
    input  logic [4:0]   Read_Register_2_i,
    output logic         issue_stall_o,
    output logic         Reg_Write_o,
    output logic [4:0]   Write_Register_o,
    output logic [N-1:0] Write_Data_o,
    output logic [31:0]  pending_o
);

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    logic         last_grant_q, last_grant_d;
    logic         reg_write_q, reg_write_d;
    logic [4:0]   wr_reg_q, wr_reg_d;
    logic [N-1:0] wr_data_q, wr_data_d;
    logic [31:0]  pending_q, pending_d;

    logic         grant_alu, grant_mem, xfer;
    logic [4:0]   xfer_rd;
    logic [N-1:0] xfer_data;
    logic         issue_set;

    // The ALU wins unless MEM also requests and the ALU was served last.
    // Requesters never gate valid on ready, so a grant is a transfer.
    assign grant_alu = alu_valid_i & (~mem_valid_i | (last_grant_q == GRANT_MEM));
    assign grant_mem = mem_valid_i & ~grant_alu;
    assign xfer      = grant_alu | grant_mem;
    assign xfer_rd   = grant_alu ? alu_rd_i   : mem_rd_i;
    assign xfer_data = grant_alu ? alu_data_i : mem_data_i;

    assign alu_ready_o = grant_alu;
    assign mem_ready_o = grant_mem;

    // The stall is taken from the registered scoreboard only. A write leaving
    // the output stage this cycle still counts as pending, because there is no
    // bypass from Write_Data_o to the readers.
    assign issue_stall_o = issue_valid_i & (
        (pending_q[Read_Register_1_i] & (Read_Register_1_i != 5'd0)) |
        (pending_q[Read_Register_2_i] & (Read_Register_2_i != 5'd0)) |
        (pending_q[issue_rd_i]        & (issue_rd_i        != 5'd0)));

    assign issue_set = issue_valid_i & ~issue_stall_o & (issue_rd_i != 5'd0);

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_alu) begin
            last_grant_d = GRANT_ALU;
        end else if (grant_mem) begin
            last_grant_d = GRANT_MEM;
        end

        // An rd=0 transfer is consumed but never reaches the register file.
        reg_write_d = xfer & (xfer_rd != 5'd0);
        wr_reg_d    = xfer ? xfer_rd   : wr_reg_q;
        wr_data_d   = xfer ? xfer_data : wr_data_q;

        // The clear is applied before the set, so the set wins on the same
        // index: the newly issued producer is still outstanding.
        pending_d = pending_q;
        if (reg_write_q) begin
            pending_d[wr_reg_q] = 1'b0;
        end
        if (issue_set) begin
            pending_d[issue_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GRANT_MEM;
            reg_write_q  <= 1'b0;
            wr_reg_q     <= 5'd0;
            wr_data_q    <= '0;
            pending_q    <= 32'd0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            wr_reg_q     <= wr_reg_d;
            wr_data_q    <= wr_data_d;
            pending_q    <= pending_d;
        end
    end

    assign Reg_Write_o      = reg_write_q;
    assign Write_Register_o = wr_reg_q;
    assign Write_Data_o     = wr_data_q;
    assign pending_o        = pending_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed self-checking bench for regfile_port_arbiter

module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid_i, mem_valid_i, issue_valid_i;
    logic [4:0]  alu_rd_i, mem_rd_i, issue_rd_i, Read_Register_1_i, Read_Register_2_i;
    logic [31:0] alu_data_i, mem_data_i;
    logic        alu_ready_o, mem_ready_o, issue_stall_o, Reg_Write_o;
    logic [4:0]  Write_Register_o;
    logic [31:0] Write_Data_o, pending_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.N(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .alu_valid_i       (alu_valid_i),
        .alu_rd_i          (alu_rd_i),
        .alu_data_i        (alu_data_i),
        .alu_ready_o       (alu_ready_o),
        .mem_valid_i       (mem_valid_i),
        .mem_rd_i          (mem_rd_i),
        .mem_data_i        (mem_data_i),
        .mem_ready_o       (mem_ready_o),
        .issue_valid_i     (issue_valid_i),
        .issue_rd_i        (issue_rd_i),
        .Read_Register_1_i (Read_Register_1_i),
        .Read_Register_2_i (Read_Register_2_i),
        .issue_stall_o     (issue_stall_o),
        .Reg_Write_o       (Reg_Write_o),
        .Write_Register_o  (Write_Register_o),
        .Write_Data_o      (Write_Data_o),
        .pending_o         (pending_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_data_i = 32'd0;
        mem_valid_i = 1'b0; mem_rd_i = 5'd0; mem_data_i = 32'd0;
        issue_valid_i = 1'b0; issue_rd_i = 5'd0;
        Read_Register_1_i = 5'd0; Read_Register_2_i = 5'd0;
        tick(); tick();
        check("rst_rw", 32'(Reg_Write_o), 32'd0);
        check("rst_wr", 32'(Write_Register_o), 32'd0);
        check("rst_wd", Write_Data_o, 32'd0);
        check("rst_pend", pending_o, 32'd0);
        check("rst_ready", {30'd0, alu_ready_o, mem_ready_o}, 32'd0);
        reset = 1'b1;

        // Single ALU write, MEM idle
        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        #1 check("t1_alu_ready", 32'(alu_ready_o), 32'd1);
        tick();
        alu_valid_i = 1'b0;
        check("t1_rw", 32'(Reg_Write_o), 32'd1);
        check("t1_wr", 32'(Write_Register_o), 32'd5);
        check("t1_wd", Write_Data_o, 32'hDEADBEEF);
        tick();
        check("t1_rw_idle", 32'(Reg_Write_o), 32'd0);
        check("t1_wr_hold", 32'(Write_Register_o), 32'd5);
        check("t1_wd_hold", Write_Data_o, 32'hDEADBEEF);

        // Lone MEM write leaves the pointer at MEM, so the ALU wins the next tie
        mem_valid_i = 1'b1; mem_rd_i = 5'd4; mem_data_i = 32'h44;
        #1 check("t2_mem_only", 32'(mem_ready_o), 32'd1);
        tick();
        mem_valid_i = 1'b0;
        check("t2_mem_wr", 32'(Write_Register_o), 32'd4);

        // Both requesters valid continuously
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h33;
        mem_valid_i = 1'b1; mem_rd_i = 5'd4; mem_data_i = 32'h44;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_alu_ready", 32'(alu_ready_o), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("t2_mem_ready", 32'(mem_ready_o), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            check("t2_rw", 32'(Reg_Write_o), 32'd1);
            check("t2_wr", 32'(Write_Register_o), (k % 2 == 0) ? 32'd3 : 32'd4);
            check("t2_wd", Write_Data_o, (k % 2 == 0) ? 32'h33 : 32'h44);
        end
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        tick();
        check("t2_rw_idle", 32'(Reg_Write_o), 32'd0);
        check("t2_pend", pending_o, 32'd0);

        // RAW hazard on r7, cleared by the MEM write
        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        #1 check("t3_stall0", 32'(issue_stall_o), 32'd0);
        tick();
        check("t3_pend7", pending_o, 32'h00000080);
        issue_rd_i = 5'd8; Read_Register_1_i = 5'd7;
        #1 check("t3_stall_raw", 32'(issue_stall_o), 32'd1);
        mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_data_i = 32'h77;
        #1 check("t3_mem_ready", 32'(mem_ready_o), 32'd1);
        tick();
        mem_valid_i = 1'b0;
        check("t3_rw", 32'(Reg_Write_o), 32'd1);
        check("t3_wr", 32'(Write_Register_o), 32'd7);
        check("t3_pend_held", pending_o, 32'h00000080);
        #1 check("t3_stall_held", 32'(issue_stall_o), 32'd1);
        tick();
        check("t3_pend_clr", pending_o, 32'd0);
        #1 check("t3_stall_drop", 32'(issue_stall_o), 32'd0);
        issue_valid_i = 1'b0; Read_Register_1_i = 5'd0;

        // Set and clear of r9 on the same edge: the set wins
        alu_valid_i = 1'b1; alu_rd_i = 5'd9; alu_data_i = 32'h99;
        #1 check("t4_alu_ready", 32'(alu_ready_o), 32'd1);
        tick();
        alu_valid_i = 1'b0;
        check("t4_rw", 32'(Reg_Write_o), 32'd1);
        issue_valid_i = 1'b1; issue_rd_i = 5'd9;
        #1 check("t4_stall0", 32'(issue_stall_o), 32'd0);
        tick();
        issue_valid_i = 1'b0;
        check("t4_pend9", pending_o, 32'h00000200);
        issue_valid_i = 1'b1;
        #1 check("t4_waw_stall", 32'(issue_stall_o), 32'd1);
        issue_valid_i = 1'b0;
        alu_valid_i = 1'b1;
        tick();
        alu_valid_i = 1'b0;
        tick();
        check("t4_pend_clr", pending_o, 32'd0);

        // rd=0 transfer and r0 issue
        alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h1234;
        #1 check("t5_alu_ready", 32'(alu_ready_o), 32'd1);
        tick();
        alu_valid_i = 1'b0;
        check("t5_rw", 32'(Reg_Write_o), 32'd0);
        check("t5_wd", Write_Data_o, 32'h1234);
        issue_valid_i = 1'b1; issue_rd_i = 5'd0;
        #1 check("t5_stall", 32'(issue_stall_o), 32'd0);
        tick();
        issue_valid_i = 1'b0;
        check("t5_pend", pending_o, 32'd0);

        // Asynchronous reset with a write in flight
        for (int r = 8; r < 12; r++) begin
            issue_valid_i = 1'b1; issue_rd_i = 5'(r);
            tick();
        end
        issue_valid_i = 1'b0;
        check("t6_pend_f00", pending_o, 32'h00000F00);
        alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 32'hAB;
        tick();
        alu_valid_i = 1'b0;
        check("t6_rw", 32'(Reg_Write_o), 32'd1);
        check("t6_pend_pre", pending_o, 32'h00000F00);
        #2 reset = 1'b0;
        #1;
        check("t6_rw_async", 32'(Reg_Write_o), 32'd0);
        check("t6_pend_async", pending_o, 32'd0);
        alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'h33;
        mem_valid_i = 1'b1; mem_rd_i = 5'd4; mem_data_i = 32'h44;
        tick();
        reset = 1'b1;
        #1;
        check("t6_alu_tie", 32'(alu_ready_o), 32'd1);
        check("t6_mem_tie", 32'(mem_ready_o), 32'd0);
        tick();
        check("t6_wr", 32'(Write_Register_o), 32'd3);
        check("t6_rw_post", 32'(Reg_Write_o), 32'd1);
        #1 check("t6_mem_next", 32'(mem_ready_o), 32'd1);
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters (ALU, MEM) with round-robin fairness and valid/ready handshakes.
- Keeps a 32-entry pending-write scoreboard and raises a stall when an issuing instruction reads or targets a register with an outstanding write.
- Sits between the issue/writeback stages and the register file. Drives its Reg_Write_i, Write_Register_i and Write_Data_i inputs from registered outputs.

Parameters:
- N, 32, datapath width of the write data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- alu_valid_i  in  1  ALU writeback request.
- alu_rd_i  in  5  ALU destination register.
- alu_data_i  in  N  ALU write data.
- alu_ready_o  out  1  ALU request granted this cycle.
- mem_valid_i  in  1  MEM writeback request.
- mem_rd_i  in  5  MEM destination register.
- mem_data_i  in  N  MEM write data.
- mem_ready_o  out  1  MEM request granted this cycle.
- issue_valid_i  in  1  instruction issue; marks issue_rd_i pending.
- issue_rd_i  in  5  destination of the issuing instruction.
- Read_Register_1_i  in  5  rs of the issuing instruction.
- Read_Register_2_i  in  5  rt of the issuing instruction.
- issue_stall_o  out  1  hazard; the issue must be held.
- Reg_Write_o  out  1  register file write enable.
- Write_Register_o  out  5  register file rd.
- Write_Data_o  out  N  register file write data.
- pending_o  out  32  scoreboard bits; bit k = write to register k outstanding.

Behaviour:
- Reset (reset=0, async): Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0, pending=0, last_grant=MEM (ALU wins the first tie).
- Arbitration is combinational on valids and last_grant:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - ready_o is high only for the granted requester. Transfer = valid & ready.
  - Requesters hold valid, rd and data stable until ready. Valid must not depend on ready.
- last_grant updates on every transfer. It is unchanged in idle cycles.
- Output stage is registered, 1-cycle latency. On a transfer in cycle t, cycle t+1 carries Write_Register_o=rd, Write_Data_o=data, and Reg_Write_o=(rd!=0).
  - A transfer with rd=0 is accepted and consumed, but Reg_Write_o stays 0.
  - With no transfer, Reg_Write_o=0 next cycle. Write_Register_o and Write_Data_o hold their last values.
- Scoreboard:
  - Set: issue_valid_i & ~issue_stall_o & issue_rd_i!=0 sets pending[issue_rd_i] at the edge.
  - Clear: Reg_Write_o=1 clears pending[Write_Register_o] at the same edge the register file captures the data. The register is therefore readable, and not stalled, from the following cycle.
  - Set and clear on the same index in the same edge: set wins, because the new producer is outstanding.
  - pending[0] is constant 0.
  - A write to a non-pending rd is legal and leaves the scoreboard unchanged.
- issue_stall_o is combinational from registered pending. It is high when issue_valid_i=1 and any of the following holds:
  - pending[Read_Register_1_i] is set and Read_Register_1_i!=0;
  - pending[Read_Register_2_i] is set and Read_Register_2_i!=0;
  - pending[issue_rd_i] is set and issue_rd_i!=0 (WAW block).
  - issue_stall_o is 0 when issue_valid_i=0.
  - An issue presented while stalled has no scoreboard effect.
- Reset asserted mid-operation: in-flight output write is dropped (Reg_Write_o=0 immediately), all pending cleared, arbitration pointer restored. Requests still held are serviced normally after release.
- No bypass from Write_Data_o to readers; hazards are resolved only by stall.

Test Plan:
- Reset release, ALU valid rd=5 data=0xDEADBEEF, MEM idle -> alu_ready_o=1 in cycle 0; cycle 1 Reg_Write_o=1, Write_Register_o=5, Write_Data_o=0xDEADBEEF; cycle 2 Reg_Write_o=0.
- ALU and MEM both valid continuously, rds 3 and 4 -> grants alternate ALU, MEM, ALU, MEM; Write_Register_o sequence 3,4,3,4 with one-cycle lag.
- Issue rd=7 (no stall) -> pending_o=0x00000080. Next issue reading rs=7 -> issue_stall_o=1. MEM writes rd=7 -> stall drops the cycle after Reg_Write_o=1 for rd 7; pending_o=0.
- Issue rd=9 in the same cycle Reg_Write_o=1 clears rd 9 -> pending[9] remains 1.
- ALU rd=0 data=0x1234 -> alu_ready_o=1, Reg_Write_o stays 0. Issue with rs=0, rt=0, rd=0 -> issue_stall_o=0, pending_o unchanged.
- pending=0x00000F00 with Reg_Write_o=1, then reset=0 asynchronously mid-cycle -> Reg_Write_o=0 and pending_o=0 before the next edge. After release, ALU wins the first tie.
